outport_uart_tx: RTL and testbench

- Downstream consumer of the CPU output port.
- Captures every word written to the OutPort register: same strobe and same bus value, sampled in the same cycle.
- Buffers captured words in a small FIFO and serialises each as 4 UART bytes (8N1, least-significant byte first) on a single tx line.
- Gives the processor a real external device for out-instructions without stalling the datapath.

---
 rtl/outport_uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_outport_uart_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/outport_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : outport_uart_tx
// Description : Captures CPU OutPort writes into a FIFO and sends each word as
//               four UART bytes, LSB first. Define OUTPORT_TX_PARITY_EN to add
//               an even-parity bit to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module outport_uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        OutPortIn,
    input  logic [31:0] BusMuxOut,
    input  logic        ovf_clr,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        overflow
);

    localparam int c_BAUD_W = $clog2(CLK_DIV);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef OUTPORT_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;

    logic [31:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [1:0]          r_byte_idx;
    logic [31:0]         r_shift;
    logic                r_overflow;

    logic                w_bit_end;
    logic                w_not_empty;
    logic                w_last_stop;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    assign w_bit_end   = (r_baud == c_BAUD_MAX);
    assign w_not_empty = (r_count != '0);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_byte_idx == 2'd3);
    assign w_pop       = w_not_empty && ((r_state == S_IDLE) || w_last_stop);
    // A write into a full FIFO survives only if a slot frees on the same edge.
    assign w_push      = OutPortIn && (!full || w_pop);
    assign w_drop      = OutPortIn && full && !w_pop;

    assign full     = (r_count == c_CNT_FULL);
    assign busy     = (r_state != S_IDLE) || w_not_empty;
    assign overflow = r_overflow;

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= BusMuxOut;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef OUTPORT_TX_PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = S_STOP;
`endif
                end
            end
`ifdef OUTPORT_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if ((r_byte_idx != 2'd3) || w_pop) begin
                        w_next_state = S_START;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[r_bit_idx];
`ifdef OUTPORT_TX_PARITY_EN
            S_PARITY: tx = ^r_shift[7:0];
`endif
            default:  tx = 1'b1;
        endcase
    end

    // Baud timing, bit/byte position and the outgoing word.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            if (w_pop) begin
                r_baud     <= '0;
                r_byte_idx <= '0;
                r_shift    <= r_mem[r_rd_ptr];
            end else if (r_state == S_IDLE) begin
                r_baud <= '0;
            end else if (w_bit_end) begin
                r_baud <= '0;
                if ((r_state == S_STOP) && (r_byte_idx != 2'd3)) begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                    r_shift    <= {8'h00, r_shift[31:8]};
                end
            end else begin
                r_baud <= r_baud + c_BAUD_W'(1);
            end
            // Eight data bits per frame, so the index wraps back to 0 on exit.
            if ((r_state == S_DATA) && w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_outport_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_outport_uart_tx
// Description : Self-checking bench for outport_uart_tx with a UART receiver
//               model and an expected-byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outport_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef OUTPORT_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CYC = 4 * FRAME_BITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        clr;
    logic        OutPortIn;
    logic [31:0] BusMuxOut;
    logic        ovf_clr;
    logic        tx;
    logic        busy;
    logic        full;
    logic        overflow;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        rx_en;
    logic [7:0]  exp_q[$];

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;

    outport_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .OutPortIn (OutPortIn),
        .BusMuxOut (BusMuxOut),
        .ovf_clr   (ovf_clr),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic write_word(input logic [31:0] w);
        OutPortIn = 1'b1;
        BusMuxOut = w;
        @(negedge clk);
        OutPortIn = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name, output int t_idle);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        t_idle = cyc;
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        check({name, "_drain"}, exp_q.size(), 32'd0);
    endtask

    // Receiver: samples mid-bit on falling clock edges.
    logic [7:0] rx_d;
    logic       rx_s;
`ifdef OUTPORT_TX_PARITY_EN
    logic       rx_p;
`endif
    initial begin
        forever begin
            @(negedge clk);
            if (clr === 1'b1 && rx_en && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    rx_d[i] = tx;
                end
`ifdef OUTPORT_TX_PARITY_EN
                repeat (CLK_DIV) @(negedge clk);
                rx_p = tx;
`endif
                repeat (CLK_DIV) @(negedge clk);
                rx_s = tx;
                if (rx_en) begin
                    check("rx_stop", {31'd0, rx_s}, 32'd1);
`ifdef OUTPORT_TX_PARITY_EN
                    check("rx_parity", {31'd0, rx_p}, {31'd0, ^rx_d});
`endif
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got byte %0h expected none", rx_d);
                    end else begin
                        check("rx_byte", {24'd0, rx_d}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        logic [10:0] seq;
        int          k, t0, t1, n1;
        logic        bad;

        tbl[0] = '{32'h4433_2211, 8'h11, 8'h22, 8'h33, 8'h44};
        tbl[1] = '{32'hDEAD_BEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        tbl[2] = '{32'h0000_0007, 8'h07, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[4] = '{32'h8001_7E18, 8'h18, 8'h7E, 8'h01, 8'h80};
`ifdef OUTPORT_TX_PARITY_EN
        seq = 11'b101_0100_1010;
`else
        seq = 11'b001_1010_0101 ^ 11'b000_0111_1111;
        seq = 11'b011_0100_1010;
`endif

        clr = 1'b0; OutPortIn = 1'b0; BusMuxOut = '0; ovf_clr = 1'b0; rx_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        clr = 1'b1;
        repeat (2) @(negedge clk);

        // Single word 0xA5: bit pattern, pop latency and word duration.
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        write_word(32'h0000_00A5);
        check("a5_tx_before_pop", {31'd0, tx}, 32'd1);
        check("a5_busy_queued", {31'd0, busy}, 32'd1);
        k = 0;
        while (tx !== 1'b0 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("a5_pop_latency", k, 32'd1);
        t0 = cyc;
        repeat (2) @(negedge clk);
        for (int b = 0; b < FRAME_BITS; b++) begin
            check("a5_bit", {31'd0, tx}, {31'd0, seq[b]});
            repeat (CLK_DIV) @(negedge clk);
        end
        wait_idle(WORD_CYC + 50, "a5", t1);
        check("a5_word_len", t1 - t0, WORD_CYC);

        // Table of single words decoded by the receiver.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tbl[i].b0); exp_q.push_back(tbl[i].b1);
            exp_q.push_back(tbl[i].b2); exp_q.push_back(tbl[i].b3);
            write_word(tbl[i].word);
            wait_idle(WORD_CYC + 50, "tbl", t1);
        end

        // Back-to-back: six writes, the sixth is dropped despite ovf_clr.
        for (int i = 1; i <= 5; i++) push_word(i);
        OutPortIn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            BusMuxOut = i;
            ovf_clr   = (i == 6);
            @(negedge clk);
            if (i == 1) t0 = cyc;
            check("b2b_full", {31'd0, full}, {31'd0, i >= 5});
            check("b2b_ovf", {31'd0, overflow}, {31'd0, i == 6});
        end
        OutPortIn = 1'b0;
        ovf_clr   = 1'b0;
        wait_idle(5 * WORD_CYC + 100, "b2b", t1);
        check("b2b_len", t1 - t0, 1 + 5 * WORD_CYC);
        check("b2b_ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("b2b_ovf_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO: write lands on the edge where the in-flight word finishes.
        for (int i = 11; i <= 16; i++) push_word(i);
        OutPortIn = 1'b1;
        for (int i = 11; i <= 15; i++) begin
            BusMuxOut = i;
            @(negedge clk);
            if (i == 11) n1 = cyc;
        end
        OutPortIn = 1'b0;
        k = 0;
        while (cyc != n1 + WORD_CYC && k < 2 * WORD_CYC) begin
            @(negedge clk);
            k++;
        end
        check("fullpop_full_before", {31'd0, full}, 32'd1);
        write_word(32'd16);
        check("fullpop_full_after", {31'd0, full}, 32'd1);
        check("fullpop_ovf", {31'd0, overflow}, 32'd0);
        wait_idle(6 * WORD_CYC + 100, "fullpop", t1);

        // Asynchronous reset in the middle of a frame.
        rx_en = 1'b0;
        OutPortIn = 1'b1;
        for (int i = 21; i <= 26; i++) begin
            BusMuxOut = i;
            @(negedge clk);
        end
        OutPortIn = 1'b0;
        repeat (CLK_DIV * 2) @(negedge clk);
        k = 0;
        while (tx !== 1'b0 && k < 4 * CLK_DIV * FRAME_BITS) begin
            @(negedge clk);
            k++;
        end
        check("rst_pre_tx", {31'd0, tx}, 32'd0);
        check("rst_pre_ovf", {31'd0, overflow}, 32'd1);
        #1 clr = 1'b0;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        clr = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("rst_stays_idle", {31'd0, bad}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
